tcp_conn_ctrl: RTL

//  Parametrised TCP connection controller: the next-generation client/server endpoint FSM.

---
 rtl/tcp_conn_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tcp_conn_ctrl.sv
// TCP connection endpoint FSM: open/listen, data, close, retransmit.
// Optional: define TCP_RST_ABORT_EN to abort on inbound RST.
module tcp_conn_ctrl #(
  parameter logic [15:0] LOCAL_PORT     = 16'd1024,
  parameter logic [31:0] ISN            = 32'h1000,
  parameter logic [15:0] WINDOW         = 16'd4096,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pkt_in_valid,
  input  logic [223:0] packet_in,
  input  logic         listen_req,
  input  logic         open_req,
  input  logic         close_req,
  input  logic [15:0]  remote_port,
  input  logic         tx_valid,
  input  logic [31:0]  tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [31:0]  rx_data,
  output logic         pkt_out_valid,
  output logic [223:0] packet_out,
  output logic [2:0]   state_o,
  output logic [3:0]   retry_cnt,
  output logic         abort
);

  typedef enum logic [2:0] {
    S_CLOSED   = 3'd0,
    S_LISTEN   = 3'd1,
    S_SYN_SENT = 3'd2,
    S_SYN_RCVD = 3'd3,
    S_ESTAB    = 3'd4,
    S_FIN_WAIT = 3'd5,
    S_LAST_ACK = 3'd6,
    S_TIME_WAIT = 3'd7
  } state_e;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RMAX = 4'(MAX_RETRIES);

  localparam logic [4:0] F_FIN = 5'b00001;
  localparam logic [4:0] F_SYN = 5'b00010;
  localparam logic [4:0] F_PSH = 5'b01000;
  localparam logic [4:0] F_ACK = 5'b10000;

  state_e         state_q, state_d;
  logic [31:0]    snd_q, snd_d;
  logic [31:0]    rcv_q, rcv_d;
  logic [15:0]    rem_q, rem_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [3:0]     rty_q, rty_d;
  logic           pv_q, pv_d;
  logic [223:0]   pkt_q, pkt_d;
  logic           rxv_q, rxv_d;
  logic [31:0]    rxd_q, rxd_d;
  logic           ab_q, ab_d;

  logic [15:0] in_dst, in_src;
  logic [31:0] in_seq, in_ackn, in_data;
  logic        in_fin, in_syn, in_psh, in_ack;
  logic        match, timed, tmo, tmo_go, rst_hit;
  logic        unused_in;

  assign in_dst  = packet_in[15:0];
  assign in_src  = packet_in[31:16];
  assign in_seq  = packet_in[63:32];
  assign in_ackn = packet_in[95:64];
  assign in_fin  = packet_in[112];
  assign in_syn  = packet_in[113];
  assign in_psh  = packet_in[115];
  assign in_ack  = packet_in[116];
  assign in_data = packet_in[223:192];
  assign unused_in = ^{packet_in[191:117], packet_in[114],
                       packet_in[111:96]};

  assign match = pkt_in_valid && (in_dst == LOCAL_PORT);
  assign timed = state_q inside {S_SYN_SENT, S_SYN_RCVD, S_FIN_WAIT,
                                 S_LAST_ACK, S_TIME_WAIT};
  assign tmo    = timed && (tmr_q == TMAX);
  assign tmo_go = tmo && !match;

`ifdef TCP_RST_ABORT_EN
  assign rst_hit = match && packet_in[114] &&
                   !(state_q inside {S_CLOSED, S_LISTEN});
`else
  assign rst_hit = 1'b0;
`endif

  assign tx_ready = (state_q == S_ESTAB) && !rst_hit &&
                    !(match && (in_fin || in_psh));

  function automatic logic [223:0] pk(
    input logic [15:0] dst,
    input logic [31:0] sq,
    input logic [31:0] ak,
    input logic [4:0]  fl,
    input logic [31:0] dat
  );
    logic [223:0] p;
    p            = '0;
    p[15:0]      = dst;
    p[31:16]     = LOCAL_PORT;
    p[63:32]     = sq;
    p[95:64]     = ak;
    p[111:96]    = WINDOW;
    p[116:112]   = fl;
    p[127:124]   = 4'd5;
    p[223:192]   = dat;
    return p;
  endfunction

  // Next state, sequence tracking and response packet selection
  always_comb begin
    state_d = state_q;
    snd_d   = snd_q;
    rcv_d   = rcv_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    rty_d   = rty_q;
    pv_d    = 1'b0;
    pkt_d   = pkt_q;
    rxv_d   = 1'b0;
    rxd_d   = rxd_q;
    ab_d    = 1'b0;
    if (rst_hit) begin
      state_d = S_CLOSED;
      ab_d    = 1'b1;
    end else begin
      unique case (state_q)
        S_CLOSED: begin
          if (open_req) begin
            rem_d   = remote_port;
            snd_d   = ISN + 32'd1;
            pv_d    = 1'b1;
            pkt_d   = pk(remote_port, ISN, '0, F_SYN, '0);
            state_d = S_SYN_SENT;
          end else if (listen_req) begin
            state_d = S_LISTEN;
          end
        end
        S_LISTEN: begin
          if (match && in_syn && !in_ack) begin
            rcv_d   = in_seq + 32'd1;
            rem_d   = in_src;
            snd_d   = ISN + 32'd1;
            pv_d    = 1'b1;
            pkt_d   = pk(in_src, ISN, in_seq + 32'd1, F_SYN | F_ACK, '0);
            state_d = S_SYN_RCVD;
          end
        end
        S_SYN_SENT: begin
          if (match && in_syn && in_ack && in_ackn == snd_q) begin
            rcv_d   = in_seq + 32'd1;
            pv_d    = 1'b1;
            pkt_d   = pk(rem_q, snd_q, in_seq + 32'd1, F_ACK, '0);
            state_d = S_ESTAB;
          end
        end
        S_SYN_RCVD: begin
          if (match && in_ack && in_ackn == snd_q) state_d = S_ESTAB;
        end
        S_ESTAB: begin
          if (match && in_fin) begin
            rcv_d   = rcv_q + 32'd1;
            pv_d    = 1'b1;
            pkt_d   = pk(rem_q, snd_q, rcv_q + 32'd1, F_FIN | F_ACK, '0);
            state_d = S_LAST_ACK;
          end else if (match && in_psh) begin
            pv_d = 1'b1;
            if (in_seq == rcv_q) begin
              rxv_d = 1'b1;
              rxd_d = in_data;
              rcv_d = rcv_q + 32'd4;
              pkt_d = pk(rem_q, snd_q, rcv_q + 32'd4, F_ACK, '0);
            end else begin
              pkt_d = pk(rem_q, snd_q, rcv_q, F_ACK, '0);
            end
          end else if (close_req) begin
            pv_d    = 1'b1;
            pkt_d   = pk(rem_q, snd_q, rcv_q, F_FIN | F_ACK, '0);
            snd_d   = snd_q + 32'd1;
            state_d = S_FIN_WAIT;
          end else if (tx_valid && tx_ready) begin
            pv_d  = 1'b1;
            pkt_d = pk(rem_q, snd_q, rcv_q, F_PSH | F_ACK, tx_data);
            snd_d = snd_q + 32'd4;
          end
        end
        S_FIN_WAIT: begin
          if (match && in_fin && in_ack && in_ackn == snd_q) begin
            rcv_d   = rcv_q + 32'd1;
            pv_d    = 1'b1;
            pkt_d   = pk(rem_q, snd_q, rcv_q + 32'd1, F_ACK, '0);
            state_d = S_TIME_WAIT;
          end
        end
        S_LAST_ACK: begin
          if (match && in_ack && in_ackn == snd_q) state_d = S_CLOSED;
        end
        S_TIME_WAIT: begin
        end
      endcase
      // A matching packet this cycle blocks tmo_go, so no transition
      // above can coincide with a timeout action here.
      if (tmo_go) begin
        if (state_q == S_TIME_WAIT) begin
          state_d = S_CLOSED;
        end else if (rty_q == RMAX) begin
          state_d = S_CLOSED;
          ab_d    = 1'b1;
        end else begin
          pv_d  = 1'b1;
          rty_d = rty_q + 4'd1;
        end
      end
    end
    if (state_d != state_q) begin
      tmr_d = '0;
      rty_d = '0;
    end else if (!timed) begin
      tmr_d = '0;
    end else if (tmo) begin
      tmr_d = match ? tmr_q : '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLOSED;
      snd_q   <= ISN;
      rcv_q   <= '0;
      rem_q   <= '0;
      tmr_q   <= '0;
      rty_q   <= '0;
      pv_q    <= 1'b0;
      pkt_q   <= '0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snd_q   <= snd_d;
      rcv_q   <= rcv_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      rty_q   <= rty_d;
      pv_q    <= pv_d;
      pkt_q   <= pkt_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      ab_q    <= ab_d;
    end
  end

  assign rx_valid      = rxv_q;
  assign rx_data       = rxd_q;
  assign pkt_out_valid = pv_q;
  assign packet_out    = pkt_q;
  assign state_o       = state_q;
  assign retry_cnt     = rty_q;
  assign abort         = ab_q;

endmodule
